text_console: RTL and testbench

- Parametrised character-cell text buffer with a built-in terminal cursor. It supersedes the fixed label RAM plus FIFO-dump display path.
- A byte stream (e.g. from the UART RX) is written into a COLS x ROWS screen. The block handles CR, LF, BS, line wrap and hardware scroll through a ring row offset.
- The VGA side looks up the character under the current pixel. It delays a sideband bus by the same latency so it can be dropped into the pixel stream pipe ahead of the font block.

---
 rtl/text_console_if.sv | 10 +
 rtl/text_console.sv | 209 ++++++++++++++++++++
 tb/tb_text_console.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_if.sv
// Byte-stream write port for the text console; valid/ready, one byte per accepted cycle.
// Ready is driven by the console and drops while it is clearing or scrolling.
interface text_console_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/text_console.sv
// Character-cell text buffer with terminal cursor (CR/LF/BS, wrap, ring-offset scroll) and a 2-cycle pixel lookup.
// Read path never stalls; write ready is low during CLEAR (COLS*ROWS cycles), SCROLL (COLS cycles) and while clear is high.
module text_console #(
    parameter int         COLS    = 40,
    parameter int         ROWS    = 30,
    parameter int         CW_LOG2 = 3,
    parameter int         CH_LOG2 = 3,
    parameter int         ZOOM    = 0,
    parameter int         XW      = 10,
    parameter int         YW      = 10,
    parameter int         SIDE_W  = 24,
    parameter logic [7:0] BLANK   = 8'h20
) (
    input  logic              clk,
    input  logic              reset_n,
    text_console_if.slave     wr,
    input  logic              clear,
    input  logic [XW-1:0]     px_x,
    input  logic [YW-1:0]     px_y,
    input  logic              px_active,
    input  logic [SIDE_W-1:0] side_in,
    output logic [7:0]        char_out,
    output logic              cell_valid,
    output logic              cursor_hit,
    output logic [SIDE_W-1:0] side_out,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row,
    output logic [5:0]        scroll_ofs
);
    localparam int              DEPTH    = COLS * ROWS;
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   COLS_A   = AW'(COLS);
    localparam logic [AW-1:0]   LAST_A   = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   LAST_C_A = AW'(COLS - 1);
    localparam logic [6:0]      LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]      LAST_ROW = 6'(ROWS - 1);
    localparam logic [6:0]      ROWS_7   = 7'(ROWS);

    typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_CLEAR} state_t;

    state_t          r_state, w_state_nxt;
    logic [6:0]      r_col, w_col_nxt;
    logic [5:0]      r_row, w_row_nxt;
    logic [5:0]      r_scroll, w_scroll_nxt;
    logic [AW-1:0]   r_cnt, w_cnt_nxt;
    logic            w_we, w_nl, w_accept;
    logic [AW-1:0]   w_waddr;
    logic [7:0]      w_wdata;
    logic [5:0]      w_phys_wr, w_scroll_row;

    // (a + b) mod ROWS for operands already below ROWS: one compare-and-subtract.
    function automatic logic [5:0] f_wrap(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= ROWS_7) s = s - ROWS_7;
        return s[5:0];
    endfunction

    function automatic logic [AW-1:0] f_addr(input logic [5:0] prow, input logic [6:0] col);
        return AW'(prow) * COLS_A + AW'(col);
    endfunction

    assign wr.wr_ready  = (r_state == S_IDLE) && !clear;
    assign w_accept     = wr.wr_valid && wr.wr_ready;
    assign w_phys_wr    = f_wrap(r_row, r_scroll);
    // r_scroll has already advanced when SCROLL runs, so the new bottom row sits one behind it.
    assign w_scroll_row = (r_scroll == 6'd0) ? LAST_ROW : r_scroll - 6'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_scroll_nxt = r_scroll;
        w_cnt_nxt    = r_cnt;
        w_we         = 1'b0;
        w_waddr      = '0;
        w_wdata      = BLANK;
        w_nl         = 1'b0;
        if (clear) begin
            w_state_nxt = S_CLEAR;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (wr.wr_data >= 8'h20 && wr.wr_data <= 8'h7E) begin
                            w_we    = 1'b1;
                            w_waddr = f_addr(w_phys_wr, r_col);
                            w_wdata = wr.wr_data;
                            if (r_col == LAST_COL) begin
                                w_col_nxt = 7'd0;
                                w_nl      = 1'b1;
                            end else begin
                                w_col_nxt = r_col + 7'd1;
                            end
                        end else if (wr.wr_data == 8'h0D) begin
                            w_col_nxt = 7'd0;
                        end else if (wr.wr_data == 8'h0A) begin
                            w_nl = 1'b1;
                        end else if (wr.wr_data == 8'h08 && r_col != 7'd0) begin
                            w_col_nxt = r_col - 7'd1;
                            w_we      = 1'b1;
                            w_waddr   = f_addr(w_phys_wr, r_col - 7'd1);
                        end
                        if (w_nl) begin
                            if (r_row != LAST_ROW) begin
                                w_row_nxt = r_row + 6'd1;
                            end else begin
                                w_scroll_nxt = (r_scroll == LAST_ROW) ? 6'd0 : r_scroll + 6'd1;
                                w_state_nxt  = S_SCROLL;
                                w_cnt_nxt    = '0;
                            end
                        end
                    end
                end
                S_SCROLL: begin
                    w_we    = 1'b1;
                    w_waddr = f_addr(w_scroll_row, 7'(r_cnt));
                    if (r_cnt == LAST_C_A) w_state_nxt = S_IDLE;
                    else                   w_cnt_nxt   = r_cnt + 1'b1;
                end
                S_CLEAR: begin
                    w_we    = 1'b1;
                    w_waddr = r_cnt;
                    if (r_cnt == LAST_A) begin
                        w_state_nxt  = S_IDLE;
                        w_col_nxt    = 7'd0;
                        w_row_nxt    = 6'd0;
                        w_scroll_nxt = 6'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_CLEAR;
            r_cnt    <= '0;
            r_col    <= 7'd0;
            r_row    <= 6'd0;
            r_scroll <= 6'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_scroll <= w_scroll_nxt;
        end
    end

    logic [XW-1:0]     w_cx;
    logic [YW-1:0]     w_cy;
    logic              w_in, w_hit;
    logic [5:0]        w_phys_rd;
    logic [AW-1:0]     w_raddr;
    logic [7:0]        r_mem [DEPTH];
    logic [7:0]        r_rdata;
    logic              r_in1, r_hit1, r_in2, r_hit2;
    logic [SIDE_W-1:0] r_side1, r_side2;
    logic [7:0]        r_char;

    assign w_cx      = (px_x >> ZOOM) >> CW_LOG2;
    assign w_cy      = (px_y >> ZOOM) >> CH_LOG2;
    assign w_in      = px_active && (w_cx < XW'(COLS)) && (w_cy < YW'(ROWS));
    assign w_phys_rd = f_wrap(w_in ? 6'(w_cy) : 6'd0, r_scroll);
    assign w_raddr   = w_in ? f_addr(w_phys_rd, 7'(w_cx)) : '0;
    assign w_hit     = w_in && (w_cx == XW'(r_col)) && (w_cy == YW'(r_row));

    // Synchronous read sees the pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_rdata <= r_mem[w_raddr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in1   <= 1'b0;
            r_hit1  <= 1'b0;
            r_side1 <= '0;
            r_in2   <= 1'b0;
            r_hit2  <= 1'b0;
            r_side2 <= '0;
            r_char  <= 8'h00;
        end else begin
            r_in1   <= w_in;
            r_hit1  <= w_hit;
            r_side1 <= side_in;
            r_in2   <= r_in1;
            r_hit2  <= r_hit1;
            r_side2 <= r_side1;
            r_char  <= r_in1 ? r_rdata : 8'h00;
        end
    end

    assign char_out   = r_char;
    assign cell_valid = r_in2;
    assign cursor_hit = r_hit2;
    assign side_out   = r_side2;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign scroll_ofs = r_scroll;
endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: default geometry plus a ZOOM=1 instance sharing the pixel inputs.
module tb_text_console;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, clear, clear_z, px_active;
    logic [9:0]  px_x, px_y;
    logic [23:0] side_in, side_out, side_z;
    logic [7:0]  char_out, char_z;
    logic        cell_valid, cell_valid_z, cursor_hit, cursor_hit_z;
    logic [6:0]  cursor_col, col_z;
    logic [5:0]  cursor_row, row_z, scroll_ofs, scroll_z;
    logic [23:0] hist [10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n, bad;

    text_console_if wif ();
    text_console_if wif_z ();

    text_console dut (
        .clk(clk), .reset_n(reset_n), .wr(wif), .clear(clear),
        .px_x(px_x), .px_y(px_y), .px_active(px_active), .side_in(side_in),
        .char_out(char_out), .cell_valid(cell_valid), .cursor_hit(cursor_hit), .side_out(side_out),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .scroll_ofs(scroll_ofs)
    );

    text_console #(.ZOOM(1)) dut_z (
        .clk(clk), .reset_n(reset_n), .wr(wif_z), .clear(clear_z),
        .px_x(px_x), .px_y(px_y), .px_active(px_active), .side_in(side_in),
        .char_out(char_z), .cell_valid(cell_valid_z), .cursor_hit(cursor_hit_z), .side_out(side_z),
        .cursor_col(col_z), .cursor_row(row_z), .scroll_ofs(scroll_z)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        while (!wif.wr_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!wif.wr_ready) chk("send_ready", {31'd0, wif.wr_ready}, 32'd1);
        wif.wr_valid = 1'b1;
        wif.wr_data  = b;
        @(negedge clk);
        wif.wr_valid = 1'b0;
    endtask

    task automatic send_byte_z(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        while (!wif_z.wr_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!wif_z.wr_ready) chk("send_ready_z", {31'd0, wif_z.wr_ready}, 32'd1);
        wif_z.wr_valid = 1'b1;
        wif_z.wr_data  = b;
        @(negedge clk);
        wif_z.wr_valid = 1'b0;
    endtask

    // Present a pixel and wait out the two-cycle lookup latency.
    task automatic read_px(input int x, input int y, input logic act);
        @(negedge clk);
        px_x      = 10'(x);
        px_y      = 10'(y);
        px_active = act;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (!wif.wr_ready && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_all_blank(input string tag);
        int errs = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++) begin
                read_px(c * 8, r * 8, 1'b1);
                if (char_out !== 8'h20 || cell_valid !== 1'b1) errs++;
            end
        chk(tag, errs, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; clear_z = 1'b0;
        px_x = '0; px_y = '0; px_active = 1'b0; side_in = '0;
        wif.wr_valid = 1'b0; wif.wr_data = '0;
        wif_z.wr_valid = 1'b0; wif_z.wr_data = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        count_busy(n);
        chk("reset_busy_cycles", n, 1200);
        chk("reset_col", cursor_col, 0);
        chk("reset_row", cursor_row, 0);
        chk("reset_scroll", scroll_ofs, 0);
        check_all_blank("init_all_blank");
        read_px(0, 0, 1'b1);
        chk("home_cursor_hit", cursor_hit, 1);

        send_byte(8'h41); send_byte(8'h42);
        read_px(0, 0, 1'b1);  chk("ab_cell0", char_out, 8'h41);
        read_px(8, 0, 1'b1);  chk("ab_cell1", char_out, 8'h42);
        chk("ab_col", cursor_col, 2);
        read_px(16, 0, 1'b1); chk("ab_cursor_hit", cursor_hit, 1);
        read_px(0, 0, 1'b1);  chk("ab_no_hit", cursor_hit, 0);

        send_byte(8'h0D);
        repeat (40) send_byte(8'h58);
        send_byte(8'h59);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            read_px(c * 8, 0, 1'b1);
            if (char_out !== 8'h58) bad++;
        end
        chk("wrap_row0_x", bad, 0);
        read_px(0, 8, 1'b1); chk("wrap_y_cell", char_out, 8'h59);
        chk("wrap_col", cursor_col, 1);
        chk("wrap_row", cursor_row, 1);

        send_byte(8'h0D);
        repeat (28) send_byte(8'h0A);
        chk("lf_row29", cursor_row, 29);
        chk("lf_no_scroll", scroll_ofs, 0);
        send_byte(8'h5A); send_byte(8'h0D); send_byte(8'h0A);
        count_busy(n);
        chk("scroll_busy_cycles", n, 40);
        chk("scroll_ofs", scroll_ofs, 1);
        chk("scroll_row", cursor_row, 29);
        chk("scroll_col", cursor_col, 0);
        read_px(0, 224, 1'b1);  chk("scroll_z_row28", char_out, 8'h5A);
        read_px(0, 232, 1'b1);  chk("scroll_bottom_c0", char_out, 8'h20);
        read_px(40, 232, 1'b1); chk("scroll_bottom_c5", char_out, 8'h20);
        read_px(0, 0, 1'b1);    chk("scroll_top_y", char_out, 8'h59);

        send_byte(8'h08);
        chk("bs_at_col0", cursor_col, 0);
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h08);
        chk("bs_col", cursor_col, 2);
        read_px(16, 232, 1'b1); chk("bs_blanked", char_out, 8'h20);
        read_px(8, 232, 1'b1);  chk("bs_kept", char_out, 8'h42);
        send_byte(8'h07);
        chk("bel_col", cursor_col, 2);
        chk("bel_row", cursor_row, 29);

        send_byte(8'h0A);
        repeat (2) @(negedge clk);
        clear = 1'b1; wif.wr_valid = 1'b1; wif.wr_data = 8'h51;
        @(negedge clk);
        clear = 1'b0; wif.wr_valid = 1'b0;
        count_busy(n);
        chk("clear_scroll_busy", n, 1200);
        chk("clear_col", cursor_col, 0);
        chk("clear_row", cursor_row, 0);
        chk("clear_scroll", scroll_ofs, 0);
        check_all_blank("clear_all_blank");

        @(negedge clk);
        clear = 1'b1; wif.wr_valid = 1'b1; wif.wr_data = 8'h51;
        #1 chk("clear_blocks_ready", wif.wr_ready, 0);
        @(negedge clk);
        clear = 1'b0; wif.wr_valid = 1'b0;
        count_busy(n);
        chk("clear_idle_busy", n, 1200);
        read_px(0, 0, 1'b1); chk("clear_byte_dropped", char_out, 8'h20);

        send_byte(8'h51);
        side_in = 24'hABCDEF;
        read_px(0, 0, 1'b1);
        chk("pre_reset_char", char_out, 8'h51);
        chk("pre_reset_side", side_out, 24'hABCDEF);
        wif.wr_valid = 1'b1; wif.wr_data = 8'h52;
        #2 reset_n = 1'b0;
        #1;
        chk("async_char", char_out, 0);
        chk("async_valid", cell_valid, 0);
        chk("async_hit", cursor_hit, 0);
        chk("async_side", side_out, 0);
        chk("async_col", cursor_col, 0);
        @(negedge clk);
        wif.wr_valid = 1'b0;
        reset_n = 1'b1;
        count_busy(n);
        chk("rerst_busy", n, 1200);
        read_px(0, 0, 1'b1); chk("rerst_blank", char_out, 8'h20);

        read_px(320, 0, 1'b1);
        chk("oob_x_valid", cell_valid, 0);
        chk("oob_x_char", char_out, 0);
        read_px(0, 240, 1'b1); chk("oob_y_valid", cell_valid, 0);
        read_px(0, 0, 1'b0);
        chk("inactive_valid", cell_valid, 0);
        chk("inactive_char", char_out, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hist[i] = 24'h13579B * 24'(i + 1);
            if (i >= 2) chk("side_delay", side_out, hist[i - 2]);
            side_in = hist[i];
        end

        send_byte_z(8'h41); send_byte_z(8'h42);
        read_px(8, 0, 1'b1);   chk("zoom_cell0", char_z, 8'h41);
        read_px(16, 0, 1'b1);  chk("zoom_cell1", char_z, 8'h42);
        chk("zoom_col", col_z, 2);
        read_px(32, 0, 1'b1);  chk("zoom_cursor_hit", cursor_hit_z, 1);
        read_px(320, 0, 1'b1);
        chk("zoom_x320_valid", cell_valid_z, 1);
        chk("zoom_x320_char", char_z, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
